// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, bubble encoding and fetch FSM states.
package mips_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [5:0]        OP_J      = 6'h02;
    localparam logic [5:0]        OP_BEQ    = 6'h04;
    localparam logic [5:0]        OP_HALT   = 6'h3F;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [DATA_W-1:0] instr);
        return instr[DATA_W-1:DATA_W-6];
    endfunction

endpackage

// File: rtl/instr_mem.sv
// 2^ADDR_W x DATA_W instruction RAM: one synchronous write port, one registered read port.
// A read and write to the same address on one edge returns the old contents; no reset.
module instr_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: reads instr_mem at pcIn into IF/ID one cycle later; stall holds IF/ID and PC,
// flush inserts a bubble. BOOT allows memory preload, a HALT opcode freezes fetch until reset.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter int         ADDR_W  = mips_pkg::ADDR_W,
    parameter int         DATA_W  = mips_pkg::DATA_W,
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic              clk,
    input  logic              fetchRst,
    input  logic              bootHold,
    input  logic              stall,
    input  logic              flush,
    input  logic              memWe,
    input  logic [ADDR_W-1:0] memWaddr,
    input  logic [DATA_W-1:0] memWdata,
    input  logic [ADDR_W-1:0] pcIn,
    output logic              counterLd,
    output logic [DATA_W-1:0] instrOut,
    output logic [ADDR_W-1:0] pcOut,
    output logic              validOut,
    output logic              jmpOut,
    output logic              branchOut,
    output logic [ADDR_W-1:0] targetOut,
    output logic              haltedOut
);

    fetch_state_e      state_q;
    logic              halted_q;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rd_dat;
    logic [5:0]        opcode;
    logic              is_halt_op;
    logic              halt_edge;
    logic              fetch_en;
    logic              in_run;

    // The memory read register is the instruction half of IF/ID; valid_q masks it to a bubble.
    instr_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (memWe),
        .waddr_i (memWaddr),
        .wdata_i (memWdata),
        .re_i    (fetch_en),
        .raddr_i (pcIn),
        .rdata_o (rd_dat)
    );

    assign instrOut   = valid_q ? rd_dat : NOP_INSTR;
    assign opcode     = opcode_of(instrOut);
    assign in_run     = (state_q == FS_RUN);
    assign is_halt_op = valid_q && (opcode == HALT_OP);
    assign halt_edge  = in_run && is_halt_op && !flush;
    assign fetch_en   = in_run && !fetchRst && !halt_edge && !flush && !stall;

    assign counterLd  = in_run && !stall && !is_halt_op;
    assign pcOut      = pc_q;
    assign validOut   = valid_q;
    assign jmpOut     = valid_q && (opcode == OP_J);
    assign branchOut  = valid_q && (opcode == OP_BEQ);
    assign targetOut  = instrOut[ADDR_W-1:0];
    assign haltedOut  = halted_q;

    always_ff @(posedge clk) begin
        if (fetchRst) begin
            state_q  <= FS_BOOT;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FS_BOOT: begin
                    if (!bootHold) begin
                        state_q <= FS_RUN;
                    end
                end
                FS_RUN: begin
                    if (halt_edge) begin
                        state_q  <= FS_HALT;
                        halted_q <= 1'b1;
                    end
                end
                FS_HALT: begin
                    state_q  <= FS_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= FS_BOOT;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Bubble causes are checked before stall so a flush always wins.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        if (!in_run || halt_edge || flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
        end else if (!stall) begin
            valid_d = 1'b1;
            pc_d    = pcIn;
        end
    end

    always_ff @(posedge clk) begin
        if (fetchRst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage with a small progCounter stand-in and a fetch scoreboard.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        fetchRst, bootHold, stall, flush, memWe;
    logic [4:0]  memWaddr;
    logic [31:0] memWdata;
    logic [4:0]  pcIn;
    logic        counterLd, validOut, jmpOut, branchOut, haltedOut;
    logic [31:0] instrOut;
    logic [4:0]  pcOut, targetOut;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] mem_model [32];
    logic [4:0]  cnt_q;

    instr_fetch_stage dut (
        .clk       (clk),
        .fetchRst  (fetchRst),
        .bootHold  (bootHold),
        .stall     (stall),
        .flush     (flush),
        .memWe     (memWe),
        .memWaddr  (memWaddr),
        .memWdata  (memWdata),
        .pcIn      (pcIn),
        .counterLd (counterLd),
        .instrOut  (instrOut),
        .pcOut     (pcOut),
        .validOut  (validOut),
        .jmpOut    (jmpOut),
        .branchOut (branchOut),
        .targetOut (targetOut),
        .haltedOut (haltedOut)
    );

    always #5 clk = ~clk;

    // progCounter stand-in: a jump redirects the current fetch address immediately.
    assign pcIn = jmpOut ? targetOut : cnt_q;
    always @(posedge clk) begin
        if (fetchRst)       cnt_q <= 5'd0;
        else if (counterLd) cnt_q <= pcIn + 5'd1;
    end

    task automatic tick(input bit fetch_exp);
        if (fetch_exp) sb_q.push_back('{pc: pcIn, instr: mem_model[pcIn]});
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        memWe = 1'b1; memWaddr = a; memWdata = d;
        tick(0);
        memWe = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic test_reset;
        fetchRst = 1'b1; bootHold = 1'b1; stall = 1'b0; flush = 1'b0;
        memWe = 1'b0; memWaddr = '0; memWdata = '0;
        tick(0); tick(0);
        checks++;
        if ({counterLd, instrOut, pcOut, validOut, jmpOut, branchOut, targetOut, haltedOut} !== 48'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ld=%b instr=%h pc=%0d v=%b j=%b b=%b t=%0d h=%b want all zero",
                     counterLd, instrOut, pcOut, validOut, jmpOut, branchOut, targetOut, haltedOut);
        end
        fetchRst = 1'b0;
        tick(0);
        checks++;
        if ({counterLd, validOut} !== 2'b00) begin
            failures++;
            $display("FAIL boot_hold: got ld=%b v=%b want ld=0 v=0", counterLd, validOut);
        end
        wr(5'd0, 32'h20010005); wr(5'd1, 32'h20020003); wr(5'd2, 32'h08000007);
        wr(5'd3, 32'hFC000000); wr(5'd4, 32'h8C050010); wr(5'd7, 32'h20030001);
        wr(5'd8, 32'h08000003);
    endtask

    task automatic test_boot_release;
        bootHold = 1'b0;
        tick(0);
        checks++;
        if ({counterLd, validOut, pcIn} !== {1'b1, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL first_run_cycle: got ld=%b v=%b pcIn=%0d want ld=1 v=0 pcIn=0", counterLd, validOut, pcIn);
        end
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, e.pc, e.instr} || e.instr !== 32'h20010005) begin
            failures++;
            $display("FAIL first_fetch: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h", validOut, pcOut, instrOut, e.pc, e.instr);
        end
    endtask

    task automatic test_stall;
        tick(1);
        e = sb_q.pop_front();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({counterLd, validOut, pcOut, instrOut} !== {1'b0, 1'b1, e.pc, e.instr}) begin
                failures++;
                $display("FAIL stall_hold%0d: got ld=%b v=%b pc=%0d instr=%h want ld=0 v=1 pc=%0d instr=%h",
                         i, counterLd, validOut, pcOut, instrOut, e.pc, e.instr);
            end
            tick(0);
        end
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, 5'd1, 32'h20020003}) begin
            failures++;
            $display("FAIL stall_end: got v=%b pc=%0d instr=%h want v=1 pc=1 instr=20020003", validOut, pcOut, instrOut);
        end
        stall = 1'b0;
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, e.pc, e.instr} || e.pc !== 5'd2) begin
            failures++;
            $display("FAIL stall_resume: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h", validOut, pcOut, instrOut, e.pc, e.instr);
        end
    endtask

    task automatic test_jump;
        checks++;
        if ({jmpOut, branchOut, targetOut, pcIn} !== {1'b1, 1'b0, 5'd7, 5'd7}) begin
            failures++;
            $display("FAIL jump_decode: got j=%b b=%b t=%0d pcIn=%0d want j=1 b=0 t=7 pcIn=7", jmpOut, branchOut, targetOut, pcIn);
        end
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, e.pc, e.instr} || e.pc !== 5'd7) begin
            failures++;
            $display("FAIL jump_target: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h", validOut, pcOut, instrOut, e.pc, e.instr);
        end
    endtask

    task automatic test_stall_flush;
        stall = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (counterLd !== 1'b0) begin
            failures++;
            $display("FAIL stall_flush_ld: got ld=%b want 0", counterLd);
        end
        tick(0);
        stall = 1'b0; flush = 1'b0;
        checks++;
        if ({validOut, instrOut, pcOut, pcIn} !== {1'b0, 32'h0, 5'd0, 5'd8}) begin
            failures++;
            $display("FAIL flush_bubble: got v=%b instr=%h pc=%0d pcIn=%0d want v=0 instr=0 pc=0 pcIn=8", validOut, instrOut, pcOut, pcIn);
        end
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut, jmpOut, targetOut} !== {1'b1, e.pc, e.instr, 1'b1, 5'd3}) begin
            failures++;
            $display("FAIL refetch_after_flush: got v=%b pc=%0d instr=%h j=%b t=%0d want v=1 pc=%0d instr=%h j=1 t=3",
                     validOut, pcOut, instrOut, jmpOut, targetOut, e.pc, e.instr);
        end
    endtask

    task automatic test_halt;
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut, counterLd, haltedOut} !== {1'b1, 5'd3, 32'hFC000000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL halt_fetch: got v=%b pc=%0d instr=%h ld=%b h=%b want v=1 pc=3 instr=fc000000 ld=0 h=0",
                     validOut, pcOut, instrOut, counterLd, haltedOut);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0);
            flush = (i % 2 == 0);
            #1;
            checks++;
            if ({haltedOut, validOut, counterLd, instrOut, pcIn} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd4}) begin
                failures++;
                $display("FAIL halted%0d: got h=%b v=%b ld=%b instr=%h pcIn=%0d want h=1 v=0 ld=0 instr=0 pcIn=4",
                         i, haltedOut, validOut, counterLd, instrOut, pcIn);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid;
        fetchRst = 1'b1; bootHold = 1'b1;
        tick(0);
        fetchRst = 1'b0; bootHold = 1'b0;
        checks++;
        if (haltedOut !== 1'b0) begin
            failures++;
            $display("FAIL halt_cleared: got h=%b want 0", haltedOut);
        end
        tick(0);
        tick(1); void'(sb_q.pop_front());
        tick(1); void'(sb_q.pop_front());
        fetchRst = 1'b1; bootHold = 1'b1;
        tick(0);
        fetchRst = 1'b0;
        checks++;
        if ({counterLd, instrOut, pcOut, validOut, jmpOut, branchOut, targetOut, haltedOut} !== 48'h0) begin
            failures++;
            $display("FAIL midrun_reset: got ld=%b instr=%h pc=%0d v=%b j=%b b=%b t=%0d h=%b want all zero",
                     counterLd, instrOut, pcOut, validOut, jmpOut, branchOut, targetOut, haltedOut);
        end
        tick(0);
        checks++;
        if ({counterLd, validOut} !== 2'b00) begin
            failures++;
            $display("FAIL midrun_boot: got ld=%b v=%b want ld=0 v=0", counterLd, validOut);
        end
        wr(5'd2, 32'h20060004); wr(5'd3, 32'h20070005);
        wr(5'd5, 32'h10000004); wr(5'd6, 32'h08000004);
        bootHold = 1'b0;
        tick(0);
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, 5'd0, 32'h20010005}) begin
            failures++;
            $display("FAIL refetch_mem0: got v=%b pc=%0d instr=%h want v=1 pc=0 instr=20010005", validOut, pcOut, instrOut);
        end
    endtask

    task automatic test_read_during_write;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            e = sb_q.pop_front();
            checks++;
            if ({validOut, pcOut, instrOut} !== {1'b1, e.pc, e.instr}) begin
                failures++;
                $display("FAIL seq_fetch%0d: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h", i, validOut, pcOut, instrOut, e.pc, e.instr);
            end
        end
        memWe = 1'b1; memWaddr = 5'd4; memWdata = 32'hDEADBEEF;
        tick(1);
        memWe = 1'b0;
        mem_model[4] = 32'hDEADBEEF;
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, 5'd4, 32'h8C050010} || e.instr !== 32'h8C050010) begin
            failures++;
            $display("FAIL rdw_old_data: got v=%b pc=%0d instr=%h want v=1 pc=4 instr=8c050010", validOut, pcOut, instrOut);
        end
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({pcOut, branchOut, jmpOut, targetOut} !== {5'd5, 1'b1, 1'b0, 5'd4}) begin
            failures++;
            $display("FAIL branch_decode: got pc=%0d b=%b j=%b t=%0d want pc=5 b=1 j=0 t=4", pcOut, branchOut, jmpOut, targetOut);
        end
        tick(1); void'(sb_q.pop_front());
        tick(1);
        e = sb_q.pop_front();
        checks++;
        if ({validOut, pcOut, instrOut} !== {1'b1, 5'd4, 32'hDEADBEEF} || e.instr !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rdw_new_data: got v=%b pc=%0d instr=%h want v=1 pc=4 instr=deadbeef", validOut, pcOut, instrOut);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_boot_release();
        test_stall();
        test_jump();
        test_stall_flush();
        test_halt();
        test_reset_mid();
        test_read_during_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
